mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage 32-bit pipeline. Sits directly downstream of the execute stage and consumes its EX/MEM register outputs.
- Performs loads and stores to data memory over a request/ready handshake. Stalls upstream while an access is outstanding.
- Owns the MEM/WB pipeline register that feeds write-back and the forwarding unit.

Parameters:
- TIMEOUT, 255: maximum REQ cycles before abort; 0 disables the timeout.
- CNT_W, 8: wait-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- Mem_WB  in  2  write-back control from EX/MEM; [1]=RegWrite, [0]=MemtoReg
- read_En  in  1  load request from EX/MEM
- write_En  in  1  store request from EX/MEM
- DataAddress  in  32  ALU result / memory address
- WriteData  in  32  store data
- dest  in  5  destination register
- mem_req  out  1  memory request valid
- mem_we  out  1  1=store, 0=load; valid while mem_req
- mem_addr  out  32  memory address
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data; valid when mem_ready
- mem_ready  in  1  memory completes the access this cycle
- stall  out  1  hold EX/MEM and all earlier stages
- mem_err  out  1  one-cycle pulse on aborted access
- WB_ctrl  out  2  MEM/WB write-back control
- ReadData  out  32  MEM/WB load data
- ALUResult  out  32  MEM/WB ALU result
- Write_Register  out  5  MEM/WB destination register
- RegWrite  out  1  equals WB_ctrl[1]; to forwarding unit

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- Async reset: every output and register is 0, wait counter is 0, and mem_req drops immediately, including mid-REQ.
- IDLE, no access (read_En=0 and write_En=0):
  - stall=0.
  - Each edge: WB_ctrl<=Mem_WB, ALUResult<=DataAddress, Write_Register<=dest, ReadData<=0.
  - Latency is 1 cycle.
- IDLE, access (read_En=1 or write_En=1):
  - stall=1 combinationally, same cycle.
  - Capture Mem_WB, DataAddress, WriteData, dest and we=write_En.
  - MEM/WB loads a bubble (WB_ctrl<=0; other fields hold).
  - Clear the counter and go to REQ.
  - If read_En and write_En are both 1, treat as a store.
- REQ:
  - mem_req=1; mem_we, mem_addr and mem_wdata come from the captured registers and are stable until ready.
  - stall=1; the counter increments each cycle.
  - mem_ready=1:
    - Load: ReadData<=mem_rdata. Store: ReadData<=0.
    - WB_ctrl, ALUResult and Write_Register load the captured values.
    - Go to DONE.
  - Counter reaches TIMEOUT (TIMEOUT≠0) without ready:
    - mem_err=1 for one cycle; WB_ctrl<=0 (result suppressed).
    - Go to DONE.
  - If mem_ready and the timeout occur in the same cycle, mem_ready wins.
- DONE:
  - stall=0, mem_req=0; MEM/WB holds.
  - read_En and write_En are ignored this cycle, because EX/MEM still presents the completed instruction.
  - Go to IDLE.
- Outside REQ: mem_req=0, mem_we=0; mem_addr and mem_wdata hold their last values.
- Pass-through of 32-bit data only; no arithmetic.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: an IDLE access with DataAddress[1:0]≠0 issues no request. mem_err pulses, MEM/WB loads a bubble, stall stays 0, and the FSM stays in IDLE.
- Undefined: the address is passed unmodified and mem_err fires only on timeout.

Test Plan:
- ALU op: Mem_WB=2'b10, DataAddress=0x00001234, dest=5, no enables -> next edge WB_ctrl=2'b10, ALUResult=0x00001234, Write_Register=5, RegWrite=1; stall=0 throughout.
- Load, ready on the 3rd REQ cycle: read_En=1, DataAddress=0x40, mem_rdata=0xDEADBEEF -> stall=1 for 4 cycles, mem_req=1 for 3 cycles with mem_addr=0x40 and mem_we=0; then ReadData=0xDEADBEEF, WB_ctrl=2'b11, DONE with stall=0, no reissue.
- Store, ready on the 1st REQ cycle: write_En=1, addr 0x80, WriteData=0xCAFEF00D -> mem_we=1, mem_wdata=0xCAFEF00D for 1 cycle; WB_ctrl=Mem_WB (2'b00); ReadData=0.
- Timeout: TIMEOUT=4, load with mem_ready held 0 -> mem_req high 4 cycles, mem_err one-cycle pulse, WB_ctrl=0, then DONE then IDLE.
- Reset in REQ: assert rst in the 2nd REQ cycle -> mem_req, stall and all outputs 0 immediately; after release, an ALU op completes normally.
- With MEM_ALIGN_CHECK_EN: read_En=1, DataAddress=0x42 -> mem_req never asserted, mem_err pulses, WB_ctrl=0, stall=0.

Source files
------------

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access stage of the 5-stage 32-bit pipeline.
//
// Takes the EX/MEM register outputs, performs loads/stores to data memory over
// a request/ready handshake, stalls upstream while an access is outstanding
// and owns the MEM/WB pipeline register feeding write-back and forwarding.
//
// Parameters:
//   TIMEOUT  maximum REQ cycles before the access is aborted (0 = no timeout)
//   CNT_W    wait-counter width, 2**CNT_W must exceed TIMEOUT
//
// Optional build macro:
//   MEM_ALIGN_CHECK_EN  when defined, an access whose address is not word
//                       aligned is rejected in IDLE: no request, mem_err pulse,
//                       MEM/WB bubble, no stall.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   Mem_WB[1:0]        write-back control from EX/MEM ([1]=RegWrite, [0]=MemtoReg)
//   read_En, write_En  load / store request from EX/MEM (both set = store)
//   DataAddress        ALU result / memory address
//   WriteData          store data
//   dest               destination register
//   mem_req/we/addr/wdata  memory request channel (we/addr/wdata valid with req)
//   mem_rdata, mem_ready   memory response (rdata valid with ready)
//   stall              hold EX/MEM and all earlier stages
//   mem_err            one-cycle pulse on an aborted access
//   WB_ctrl, ReadData, ALUResult, Write_Register  MEM/WB register
//   RegWrite           WB_ctrl[1], to the forwarding unit
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  Mem_WB,
    input  logic        read_En,
    input  logic        write_En,
    input  logic [31:0] DataAddress,
    input  logic [31:0] WriteData,
    input  logic [4:0]  dest,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic        mem_err,
    output logic [1:0]  WB_ctrl,
    output logic [31:0] ReadData,
    output logic [31:0] ALUResult,
    output logic [4:0]  Write_Register,
    output logic        RegWrite
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;

    // Instruction captured at the start of an access; EX/MEM is held by stall
    // but these keep the request stable regardless of upstream behaviour.
    logic             cap_we;
    logic [1:0]       cap_wb;
    logic [4:0]       cap_dest;
    logic [31:0]      cap_addr;
    logic [31:0]      cap_wdata;

    logic             access;
    logic             misaligned;
    logic             start;
    logic             align_fault;
    logic             in_req;
    logic             timeout_hit;

    assign access = read_En | write_En;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (DataAddress[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign start       = (state == IDLE) && access && !misaligned;
    assign align_fault = (state == IDLE) && access && misaligned;
    assign in_req      = (state == REQ);

    // The counter value after this REQ cycle equals the number of REQ cycles
    // spent so far; reaching TIMEOUT aborts on that cycle unless ready wins.
    assign wait_cnt_inc = wait_cnt + 1'b1;
    assign timeout_hit  = (TIMEOUT != 0) && (wait_cnt_inc == TIMEOUT_CNT);

    assign mem_req   = in_req;
    assign mem_we    = in_req & cap_we;
    assign mem_addr  = cap_addr;
    assign mem_wdata = cap_wdata;

    // stall is combinational from read_En/write_En; gating with rst keeps it
    // low for the whole reset window even if upstream still presents an access.
    assign stall    = (start | in_req) & ~rst;
    assign RegWrite = WB_ctrl[1];

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            cap_we         <= 1'b0;
            cap_wb         <= 2'b00;
            cap_dest       <= 5'd0;
            cap_addr       <= 32'd0;
            cap_wdata      <= 32'd0;
            mem_err        <= 1'b0;
            WB_ctrl        <= 2'b00;
            ReadData       <= 32'd0;
            ALUResult      <= 32'd0;
            Write_Register <= 5'd0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cap_we    <= write_En;
                        cap_wb    <= Mem_WB;
                        cap_dest  <= dest;
                        cap_addr  <= DataAddress;
                        cap_wdata <= WriteData;
                        wait_cnt  <= '0;
                        WB_ctrl   <= 2'b00;
                        state     <= REQ;
                    end else if (align_fault) begin
                        mem_err <= 1'b1;
                        WB_ctrl <= 2'b00;
                    end else begin
                        WB_ctrl        <= Mem_WB;
                        ALUResult      <= DataAddress;
                        Write_Register <= dest;
                        ReadData       <= 32'd0;
                    end
                end
                REQ: begin
                    wait_cnt <= wait_cnt_inc;
                    if (mem_ready) begin
                        ReadData       <= cap_we ? 32'd0 : mem_rdata;
                        WB_ctrl        <= cap_wb;
                        ALUResult      <= cap_addr;
                        Write_Register <= cap_dest;
                        state          <= DONE;
                    end else if (timeout_hit) begin
                        mem_err <= 1'b1;
                        WB_ctrl <= 2'b00;
                        state   <= DONE;
                    end
                end
                // EX/MEM still shows the completed instruction here, so its
                // enables are ignored and MEM/WB holds for one cycle.
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- directed self-checking bench for mem_stage (TIMEOUT=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [1:0]  Mem_WB;
    logic        read_En;
    logic        write_En;
    logic [31:0] DataAddress;
    logic [31:0] WriteData;
    logic [4:0]  dest;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic        mem_err;
    logic [1:0]  WB_ctrl;
    logic [31:0] ReadData;
    logic [31:0] ALUResult;
    logic [4:0]  Write_Register;
    logic        RegWrite;

    int checks = 0;
    int errors = 0;

    mem_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .Mem_WB         (Mem_WB),
        .read_En        (read_En),
        .write_En       (write_En),
        .DataAddress    (DataAddress),
        .WriteData      (WriteData),
        .dest           (dest),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .stall          (stall),
        .mem_err        (mem_err),
        .WB_ctrl        (WB_ctrl),
        .ReadData       (ReadData),
        .ALUResult      (ALUResult),
        .Write_Register (Write_Register),
        .RegWrite       (RegWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        Mem_WB      = 2'b00;
        read_En     = 1'b0;
        write_En    = 1'b0;
        DataAddress = 32'd0;
        WriteData   = 32'd0;
        dest        = 5'd0;
        mem_rdata   = 32'd0;
        mem_ready   = 1'b0;

        // Reset state
        #12;
        check("rst_mem_req", mem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_wb_ctrl", WB_ctrl, 0);
        check("rst_readdata", ReadData, 0);
        check("rst_aluresult", ALUResult, 0);
        check("rst_wreg", Write_Register, 0);
        check("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        // ALU op: one-cycle pass-through
        Mem_WB = 2'b10; DataAddress = 32'h0000_1234; dest = 5'd5;
        #1;
        check("alu_stall", stall, 0);
        step();
        check("alu_wb_ctrl", WB_ctrl, 2'b10);
        check("alu_aluresult", ALUResult, 32'h0000_1234);
        check("alu_wreg", Write_Register, 5);
        check("alu_regwrite", RegWrite, 1);
        check("alu_readdata", ReadData, 0);
        check("alu_stall_after", stall, 0);

        // Load, ready on the 3rd REQ cycle
        Mem_WB = 2'b11; read_En = 1'b1; DataAddress = 32'h40; dest = 5'd7;
        WriteData = 32'h1111_1111;
        #1;
        check("ld_idle_stall", stall, 1);
        check("ld_idle_req", mem_req, 0);
        step();
        check("ld_req1_req", mem_req, 1);
        check("ld_req1_stall", stall, 1);
        check("ld_req1_addr", mem_addr, 32'h40);
        check("ld_req1_we", mem_we, 0);
        check("ld_bubble_wb", WB_ctrl, 0);
        check("ld_bubble_hold_alu", ALUResult, 32'h0000_1234);
        step();
        check("ld_req2_req", mem_req, 1);
        check("ld_req2_stall", stall, 1);
        step();
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("ld_req3_req", mem_req, 1);
        check("ld_req3_stall", stall, 1);
        step();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        check("ld_done_readdata", ReadData, 32'hDEAD_BEEF);
        check("ld_done_wb", WB_ctrl, 2'b11);
        check("ld_done_alu", ALUResult, 32'h40);
        check("ld_done_wreg", Write_Register, 7);
        check("ld_done_stall", stall, 0);
        check("ld_done_req", mem_req, 0);
        step();
        check("ld_idle_noreissue", mem_req, 0);
        check("ld_idle_hold_rd", ReadData, 32'hDEAD_BEEF);

        // Store, ready on the 1st REQ cycle
        read_En = 1'b0; write_En = 1'b1; DataAddress = 32'h80;
        WriteData = 32'hCAFE_F00D; Mem_WB = 2'b00; dest = 5'd9;
        #1;
        check("st_idle_stall", stall, 1);
        step();
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        check("st_req_req", mem_req, 1);
        check("st_req_we", mem_we, 1);
        check("st_req_wdata", mem_wdata, 32'hCAFE_F00D);
        check("st_req_addr", mem_addr, 32'h80);
        step();
        mem_ready = 1'b0;
        check("st_done_readdata", ReadData, 0);
        check("st_done_wb", WB_ctrl, 2'b00);
        check("st_done_alu", ALUResult, 32'h80);
        check("st_done_wreg", Write_Register, 9);
        check("st_done_we", mem_we, 0);
        check("st_done_wdata_hold", mem_wdata, 32'hCAFE_F00D);
        step();

        // Both enables set: treated as a store
        read_En = 1'b1; write_En = 1'b1; DataAddress = 32'h84;
        WriteData = 32'h0BAD_CAFE; Mem_WB = 2'b10; dest = 5'd3;
        step();
        check("both_we", mem_we, 1);
        mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
        step();
        mem_ready = 1'b0;
        check("both_readdata", ReadData, 0);
        check("both_wb", WB_ctrl, 2'b10);
        step();

        // Timeout with TIMEOUT=4
        read_En = 1'b1; write_En = 1'b0; DataAddress = 32'h100;
        Mem_WB = 2'b11; dest = 5'd4;
        step();
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("to_req%0d_req", i), mem_req, 1);
            check($sformatf("to_req%0d_err", i), mem_err, 0);
            step();
        end
        check("to_done_err", mem_err, 1);
        check("to_done_wb", WB_ctrl, 0);
        check("to_done_req", mem_req, 0);
        check("to_done_stall", stall, 0);
        step();
        read_En = 1'b0;
        check("to_idle_err", mem_err, 0);
        check("to_idle_wb", WB_ctrl, 0);
        check("to_idle_req", mem_req, 0);
        step();

        // Reset asserted in the 2nd REQ cycle
        read_En = 1'b1; DataAddress = 32'h200; Mem_WB = 2'b11; dest = 5'd6;
        step();
        step();
        check("rr_req2_req", mem_req, 1);
        rst = 1'b1;
        #1;
        check("rr_req", mem_req, 0);
        check("rr_stall", stall, 0);
        check("rr_we", mem_we, 0);
        check("rr_addr", mem_addr, 0);
        check("rr_wb", WB_ctrl, 0);
        check("rr_alu", ALUResult, 0);
        check("rr_wreg", Write_Register, 0);
        check("rr_regwrite", RegWrite, 0);
        check("rr_err", mem_err, 0);
        read_En = 1'b0; Mem_WB = 2'b10; DataAddress = 32'h0000_ABCD; dest = 5'd12;
        @(negedge clk);
        rst = 1'b0;
        step();
        check("rr_alu_wb", WB_ctrl, 2'b10);
        check("rr_alu_result", ALUResult, 32'h0000_ABCD);
        check("rr_alu_wreg", Write_Register, 12);
        check("rr_alu_stall", stall, 0);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned load is rejected without a request
        read_En = 1'b1; DataAddress = 32'h42; Mem_WB = 2'b11; dest = 5'd8;
        #1;
        check("al_stall", stall, 0);
        check("al_req_idle", mem_req, 0);
        step();
        read_En = 1'b0; Mem_WB = 2'b00;
        check("al_err", mem_err, 1);
        check("al_wb", WB_ctrl, 0);
        check("al_req", mem_req, 0);
        check("al_alu_hold", ALUResult, 32'h0000_ABCD);
        step();
        check("al_err_clear", mem_err, 0);
        check("al_req_after", mem_req, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
